// File: rtl/matmul_stream_core.sv
// Streaming signed NxN matrix multiplier: load A/B pairs, one MAC per cycle, stream C row-major.
// Optional build macro MATMUL_SAT_EN: saturate results to OUT_W bits instead of wrapping.
module matmul_stream_core #(
    parameter int N     = 2,
    parameter int W     = 2,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a_in,
    input  logic [W-1:0]     b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] c_out,
    output logic             busy
);

    localparam int ACC_W = 2 * W + $clog2(N);
    localparam int IDX_W = $clog2(N);
    localparam int EL    = N * N;
    localparam int EL_W  = $clog2(EL);
    localparam int WIDE  = (ACC_W > OUT_W) ? ACC_W : OUT_W;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [EL_W-1:0]  EL_LAST  = EL_W'(EL - 1);

`ifdef MATMUL_SAT_EN
    localparam logic signed [WIDE-1:0] SAT_MAX = WIDE'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [WIDE-1:0] SAT_MIN = ~SAT_MAX;
`endif

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        OUTPUT
    } stateT;

    stateT state;
    stateT nextState;

    logic [EL_W-1:0]  loadIdx;
    logic [EL_W-1:0]  outIdx;
    logic [IDX_W-1:0] iIdx;
    logic [IDX_W-1:0] jIdx;
    logic [IDX_W-1:0] kIdx;

    logic signed [ACC_W-1:0] acc;
    logic signed [W-1:0]     matA [EL];
    logic signed [W-1:0]     matB [EL];
    logic signed [ACC_W-1:0] matC [EL];

    logic [EL_W-1:0]         aAddr;
    logic [EL_W-1:0]         bAddr;
    logic [EL_W-1:0]         cAddr;
    logic signed [ACC_W-1:0] aExt;
    logic signed [ACC_W-1:0] bExt;
    logic signed [ACC_W-1:0] macSum;
    logic                    loadLast;
    logic                    computeLast;
    logic                    outLast;

    // Narrowing of the exact accumulator value to the output lane width.
    function automatic logic [OUT_W-1:0] fmt(input logic signed [ACC_W-1:0] value);
        logic signed [WIDE-1:0] wideVal;
        wideVal = WIDE'(value);
`ifdef MATMUL_SAT_EN
        if (wideVal > SAT_MAX) begin
            wideVal = SAT_MAX;
        end else if (wideVal < SAT_MIN) begin
            wideVal = SAT_MIN;
        end
`endif
        return OUT_W'(wideVal);
    endfunction

    always_comb begin
        aAddr       = EL_W'(int'(iIdx) * N + int'(kIdx));
        bAddr       = EL_W'(int'(kIdx) * N + int'(jIdx));
        cAddr       = EL_W'(int'(iIdx) * N + int'(jIdx));
        aExt        = ACC_W'(matA[aAddr]);
        bExt        = ACC_W'(matB[bAddr]);
        macSum      = ((kIdx == '0) ? '0 : acc) + aExt * bExt;
        loadLast    = (loadIdx == EL_LAST);
        outLast     = (outIdx == EL_LAST);
        computeLast = (iIdx == IDX_LAST) && (jIdx == IDX_LAST) && (kIdx == IDX_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= nextState;
        end
    end

    // ena gates every transition, so a low ena freezes the FSM in place.
    always_comb begin
        nextState = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        c_out     = fmt(matC[outIdx]);
        unique case (state)
            LOAD: begin
                in_ready = ena;
                if (ena && in_valid && loadLast) begin
                    nextState = COMPUTE;
                end
            end
            COMPUTE: begin
                busy = 1'b1;
                if (ena && computeLast) begin
                    nextState = OUTPUT;
                end
            end
            OUTPUT: begin
                out_valid = ena;
                if (ena && out_ready && outLast) begin
                    nextState = LOAD;
                end
            end
            default: nextState = LOAD;
        endcase
    end

    // Every counter wraps to zero on its final step, so returning to LOAD leaves them cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loadIdx <= '0;
            outIdx  <= '0;
            iIdx    <= '0;
            jIdx    <= '0;
            kIdx    <= '0;
            acc     <= '0;
            for (int e = 0; e < EL; e++) begin
                matA[e] <= '0;
                matB[e] <= '0;
                matC[e] <= '0;
            end
        end else if (ena) begin
            unique case (state)
                LOAD: begin
                    if (in_valid) begin
                        matA[loadIdx] <= $signed(a_in);
                        matB[loadIdx] <= $signed(b_in);
                        loadIdx       <= loadLast ? '0 : loadIdx + EL_W'(1);
                    end
                end
                COMPUTE: begin
                    acc <= macSum;
                    if (kIdx == IDX_LAST) begin
                        kIdx        <= '0;
                        matC[cAddr] <= macSum;
                        if (jIdx == IDX_LAST) begin
                            jIdx <= '0;
                            iIdx <= (iIdx == IDX_LAST) ? '0 : iIdx + IDX_W'(1);
                        end else begin
                            jIdx <= jIdx + IDX_W'(1);
                        end
                    end else begin
                        kIdx <= kIdx + IDX_W'(1);
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        outIdx <= outLast ? '0 : outIdx + EL_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/matmul_stream_core.md
# matmul_stream_core

Parametrised signed N×N matrix multiplier, successor to the fixed 2×2, 2-bit demo multiplier. Operands A and B are streamed in element-pairs over a valid/ready input, C = A·B is computed with one shared multiply-accumulate per cycle, and C is streamed out row-major over a valid/ready output. It sits behind the TinyTapeout top-level wrapper, which maps `ui_in`/`uio_in` to the operand lanes and `uo_out` to the result lane.

## Interface
- `N`, default 2: matrix dimension (N ≥ 2).
- `W`, default 2: operand element width, signed two's complement.
- `OUT_W`, default 8: result element width on `c_out`.
- Derived, not overridable: `ACC_W` = 2·W + clog2(N), the internal signed accumulator width. It is exact for all operand values.

Ports:
- `clk` in 1: the single clock. All state is on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `ena` in 1: design select. When low, all state is frozen.
- `in_valid` in 1: `a_in`/`b_in` carry a valid element pair.
- `in_ready` out 1: the block accepts an element pair.
- `a_in` in W: element of A, row-major.
- `b_in` in W: element of B, row-major.
- `out_valid` out 1: `c_out` holds a valid result element.
- `out_ready` in 1: the consumer accepts `c_out`.
- `c_out` out OUT_W: element of C, row-major.
- `busy` out 1: high while in COMPUTE.

## Operation
- FSM has three states: LOAD → COMPUTE → OUTPUT → LOAD.
- LOAD state:
  - `in_ready` = `ena`.
  - Each accepted beat (`in_valid & in_ready`) writes `a_in` to A[k] and `b_in` to B[k], with k = row·N + col. k starts at 0.
  - The beat with k = N²−1 moves the FSM to COMPUTE.
- COMPUTE state:
  - Loop order is i, j, then k, each from 0 to N−1.
  - One MAC per cycle: acc ← (k==0 ? 0 : acc) + sext(A[i][k])·sext(B[k][j]).
  - When k = N−1, the final sum is written to C[i][j].
  - After N³ cycles the FSM moves to OUTPUT.
- OUTPUT state:
  - `out_valid` = 1 and `c_out` = fmt(C[m]), with m from 0 to N²−1.
  - m advances on `out_valid & out_ready`.
  - Accepting m = N²−1 returns the FSM to LOAD with all counters cleared.
- `c_out` and `out_valid` are stable while `out_valid & !out_ready`.
- `ena` = 0:
  - `in_ready` = 0 and `out_valid` = 0.
  - FSM, counters, accumulator and buffers hold.
  - Operation resumes where it stopped when `ena` returns to 1.
- `in_valid` is ignored outside LOAD. `out_ready` is ignored outside OUTPUT.
- Reset (any time, including mid-COMPUTE or mid-OUTPUT):
  - FSM goes to LOAD and all counters are cleared.
  - acc, A, B and C are cleared to 0.
  - `out_valid` = 0, `c_out` = 0, `busy` = 0.
  - `in_ready` follows `ena` immediately after `rst_n` rises.

## Timing
- Input: one element pair per cycle at full rate. The last accepted beat at edge t gives `busy` = 1 from t.
- Compute latency is exactly N³ cycles. The first `out_valid` appears at edge t + N³.
- Output: one element per cycle while `out_ready` = 1. `in_ready` rises on the edge that accepts the last C element.
- Back-to-back: the minimum period per product is 2·N² + N³ cycles.
- `in_ready`, `out_valid` and `busy` are decoded from registered state only. There is no combinational path from `in_valid`/`out_ready` to any output.

## Configuration
- Macro `MATMUL_SAT_EN` selects how fmt() narrows the ACC_W-bit sum to OUT_W bits.
- Defined: fmt saturates to the signed OUT_W range [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- Undefined: fmt keeps the low OUT_W bits (two's-complement wrap).
- If OUT_W ≥ ACC_W, fmt sign-extends in both builds.

## Test plan
- Basic 2×2 (N=2, W=2, OUT_W=8):
  - Stimulus: A = [1,1;−1,−2], B = [−1,1;−1,1], streamed at full rate.
  - Required: `c_out` = 0xFE, 0x02, 0x03, 0xFD, with `out_valid` 8 cycles after the last input beat.
- Backpressure: same vectors, `out_ready` held low 5 cycles on element 1 → `c_out` = 0x02 stays stable and no element is lost or duplicated.
- Saturation (N=4, W=4, OUT_W=8):
  - Stimulus: all A = B = −8, so every sum is 256.
  - Required: every `c_out` = 0x7F with `MATMUL_SAT_EN` defined, 0x00 without.
- `ena` gaps:
  - Stimulus: drop `ena` for 3 cycles mid-LOAD, mid-COMPUTE and mid-OUTPUT.
  - Required: handshakes stall, results are identical to the basic 2×2 test, and latency grows by exactly 9 cycles.
- Reset mid-COMPUTE:
  - Stimulus: assert `rst_n` low asynchronously 3 cycles into COMPUTE.
  - Required: all outputs are 0 within the reset, and the FSM is in LOAD.
  - A fresh load of A = I, B = [1,−2;0,1] then yields 0x01, 0xFE, 0x00, 0x01.
- Back-to-back: two products streamed with `in_valid` always high → second result is correct, and `in_ready` is low from the last accepted LOAD beat until the last C element is accepted.
